decode_control: RTL and testbench

Multi-cycle instruction sequencer that drives the control side of the processor datapath. It fetches 32-bit RV32I-subset instructions from instruction memory over a req/ack handshake. It decodes each instruction into ALU op, register addresses, immediate, operand select and write-enable, and retires one instruction per pass through a four-state FSM. It sits between instruction memory and the datapath, and owns the PC.

---
 rtl/decode_control.sv | 184 ++++++++++++++++++
 tb/tb_decode_control.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_control.sv
// Multi-cycle RV32I-subset fetch/decode sequencer: owns the PC, fetches over req/ack and
// decodes into datapath controls. Optional fetch timeout: define DECODE_CTRL_FETCH_TIMEOUT_EN.
module decode_control (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [6:0]  op,
  output logic [4:0]  addr_a,
  output logic [4:0]  addr_b,
  output logic [4:0]  addr_d,
  output logic [31:0] immed,
  output logic        y_sel,
  output logic        write,
  output logic        halted,
  output logic        error,
  output logic [31:0] retired
);

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_WB     = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_SYS = 7'b1110011;

  logic [2:0]  state_r;
  logic [2:0]  next_state_s;
  logic [31:0] pc_r;
  logic [31:0] ir_r;
  logic [31:0] retired_r;
  logic        halted_r;
  logic        error_r;
  logic        set_halt_s;
  logic        set_error_s;
  logic        fetch_timeout_s;

  function automatic logic is_alu_opcode(input logic [6:0] opc);
    is_alu_opcode = (opc == OPC_R) || (opc == OPC_I) || (opc == OPC_LUI);
  endfunction

`ifdef DECODE_CTRL_FETCH_TIMEOUT_EN
  logic [3:0] wait_cnt_r;

  // Consecutive no-ack FETCH cycles; held at zero outside FETCH so every entry starts clean.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_r <= 4'd0;
    end else if (state_r != ST_FETCH) begin
      wait_cnt_r <= 4'd0;
    end else if (!imem_ack) begin
      wait_cnt_r <= wait_cnt_r + 4'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Sixteenth cycle without ack; an ack in that same cycle takes priority.
  assign fetch_timeout_s = (state_r == ST_FETCH) && !imem_ack && (wait_cnt_r == 4'd15);
`else
  assign fetch_timeout_s = 1'b0;
`endif

  // Next-state selection and halt/fault classification.
  always_comb begin
    next_state_s = state_r;
    set_halt_s   = 1'b0;
    set_error_s  = 1'b0;
    case (state_r)
      ST_FETCH: begin
        if (imem_ack) begin
          next_state_s = ST_DECODE;
        end else if (fetch_timeout_s) begin
          next_state_s = ST_HALT;
          set_halt_s   = 1'b1;
          set_error_s  = 1'b1;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (is_alu_opcode(ir_r[6:0])) begin
          next_state_s = ST_EXEC;
        end else if (ir_r[6:0] == OPC_SYS) begin
          next_state_s = ST_HALT;
          set_halt_s   = 1'b1;
        end else begin
          next_state_s = ST_HALT;
          set_halt_s   = 1'b1;
          set_error_s  = 1'b1;
        end
      end
      ST_EXEC: next_state_s = ST_WB;
      ST_WB:   next_state_s = ST_FETCH;
      ST_HALT: next_state_s = ST_HALT;
      default: begin
        // Corrupted state encoding is treated as a fault.
        next_state_s = ST_HALT;
        set_halt_s   = 1'b1;
        set_error_s  = 1'b1;
      end
    endcase
  end

  // State, PC, instruction register, retire counter and sticky status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_FETCH;
      pc_r      <= 32'd0;
      ir_r      <= 32'd0;
      retired_r <= 32'd0;
      halted_r  <= 1'b0;
      error_r   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if ((state_r == ST_FETCH) && imem_ack) begin
        ir_r <= imem_data;
      end else begin
        ir_r <= ir_r;
      end
      if (state_r == ST_WB) begin
        pc_r      <= pc_r + 32'd4;
        retired_r <= retired_r + 32'd1;
      end else begin
        pc_r      <= pc_r;
        retired_r <= retired_r;
      end
      halted_r <= halted_r | set_halt_s;
      error_r  <= error_r | set_error_s;
    end
  end

  // Field decode straight from the instruction register; non-ALU opcodes decode to all zeros.
  always_comb begin
    op     = 7'd0;
    addr_a = 5'd0;
    addr_b = 5'd0;
    addr_d = 5'd0;
    immed  = 32'd0;
    y_sel  = 1'b0;
    case (ir_r[6:0])
      OPC_R: begin
        addr_a = ir_r[19:15];
        addr_b = ir_r[24:20];
        addr_d = ir_r[11:7];
        y_sel  = 1'b1;
        op     = {ir_r[30], 3'b000, ir_r[14:12]};
      end
      OPC_I: begin
        addr_a = ir_r[19:15];
        addr_d = ir_r[11:7];
        immed  = {{20{ir_r[31]}}, ir_r[31:20]};
        // Only the shift-right funct3 carries the arithmetic/logical bit.
        if (ir_r[14:12] == 3'b101) begin
          op = {ir_r[30], 3'b000, ir_r[14:12]};
        end else begin
          op = {1'b0, 3'b000, ir_r[14:12]};
        end
      end
      OPC_LUI: begin
        addr_d = ir_r[11:7];
        immed  = {ir_r[31:12], 12'h000};
      end
      default: begin
        op = 7'd0;
      end
    endcase
  end

  // Strobes are gated by reset so they drop the instant reset asserts.
  assign imem_req  = (state_r == ST_FETCH) && !reset;
  assign write     = (state_r == ST_WB) && (addr_d != 5'd0) && !reset;
  assign imem_addr = pc_r;
  assign halted    = halted_r;
  assign error     = error_r;
  assign retired   = retired_r;

endmodule

// File: tb/tb_decode_control.sv
// Directed self-checking bench for decode_control; timeout checks follow
// DECODE_CTRL_FETCH_TIMEOUT_EN when it is defined for the build.
module tb_decode_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = 32'd0;
  logic [6:0]  op;
  logic [4:0]  addr_a, addr_b, addr_d;
  logic [31:0] immed;
  logic        y_sel, write, halted, error;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  decode_control dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .op(op), .addr_a(addr_a), .addr_b(addr_b), .addr_d(addr_d),
    .immed(immed), .y_sel(y_sel), .write(write),
    .halted(halted), .error(error), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    imem_ack = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  // Present a word with same-cycle ack; returns 1 ns after the edge that enters DECODE.
  task automatic serve(input logic [31:0] w);
    imem_data = w;
    imem_ack  = 1'b1;
    step();
    imem_ack  = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #3;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
    checks++; if (write !== 1'b0) begin errors++; $display("FAIL reset_write: got %b want 0", write); end
    apply_reset();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL post_reset_req: got %b want 1", imem_req); end
    checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL post_reset_addr: got %h want 0", imem_addr); end
    checks++; if ({retired, halted, error} !== 34'd0) begin errors++; $display("FAIL post_reset_status: got %h/%b/%b want 0", retired, halted, error); end
    checks++; if ({op, addr_a, addr_b, addr_d, immed, y_sel} !== 55'd0) begin errors++; $display("FAIL post_reset_decode: got op=%h imm=%h want 0", op, immed); end
  endtask

  task automatic test_addi;
    serve(32'h00500093);
    step();
    checks++; if (write !== 1'b0) begin errors++; $display("FAIL addi_exec_write: got %b want 0", write); end
    step();
    checks++; if (write !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL addi_wb_strobes: got write=%b req=%b want 1/0", write, imem_req); end
    checks++; if ({addr_a, addr_d, immed, y_sel, op} !== {5'd0, 5'd1, 32'd5, 1'b0, 7'd0}) begin
      errors++; $display("FAIL addi_fields: got a=%0d d=%0d imm=%h ysel=%b op=%h want 0/1/5/0/0", addr_a, addr_d, immed, y_sel, op);
    end
    step();
    checks++; if (write !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL addi_after_wb: got write=%b req=%b want 0/1", write, imem_req); end
    checks++; if (imem_addr !== 32'd4 || retired !== 32'd1) begin errors++; $display("FAIL addi_pc_retired: got %h/%0d want 4/1", imem_addr, retired); end
  endtask

  task automatic test_add_sub;
    serve(32'h002081B3);
    step(); step();
    checks++; if ({addr_a, addr_b, addr_d, y_sel, op, write} !== {5'd1, 5'd2, 5'd3, 1'b1, 7'h00, 1'b1}) begin
      errors++; $display("FAIL add_fields: got a=%0d b=%0d d=%0d ysel=%b op=%h w=%b want 1/2/3/1/00/1", addr_a, addr_b, addr_d, y_sel, op, write);
    end
    step();
    serve(32'h402081B3);
    step(); step();
    checks++; if ({addr_a, addr_b, addr_d, y_sel, op, write} !== {5'd1, 5'd2, 5'd3, 1'b1, 7'h40, 1'b1}) begin
      errors++; $display("FAIL sub_fields: got a=%0d b=%0d d=%0d ysel=%b op=%h w=%b want 1/2/3/1/40/1", addr_a, addr_b, addr_d, y_sel, op, write);
    end
    step();
    checks++; if (imem_addr !== 32'd12 || retired !== 32'd3) begin errors++; $display("FAIL sub_pc_retired: got %h/%0d want c/3", imem_addr, retired); end
  endtask

  task automatic test_wait_lui;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (imem_addr !== 32'd12 || imem_req !== 1'b1) begin errors++; $display("FAIL wait_addr_stable: got %h/%b want c/1", imem_addr, imem_req); end
    end
    serve(32'h123452B7);
    step(); step();
    checks++; if ({immed, addr_a, addr_d, y_sel, write} !== {32'h12345000, 5'd0, 5'd5, 1'b0, 1'b1}) begin
      errors++; $display("FAIL lui_fields: got imm=%h a=%0d d=%0d ysel=%b w=%b want 12345000/0/5/0/1", immed, addr_a, addr_d, y_sel, write);
    end
    step();
    checks++; if (imem_addr !== 32'd16 || retired !== 32'd4) begin errors++; $display("FAIL lui_pc_retired: got %h/%0d want 10/4", imem_addr, retired); end
  endtask

  task automatic test_x0_dest;
    int wcount;
    apply_reset();
    serve(32'h00000013);
    wcount = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (write === 1'b1) wcount++;
    end
    checks++; if (wcount !== 0) begin errors++; $display("FAIL x0_no_write: got %0d pulses want 0", wcount); end
    checks++; if (imem_addr !== 32'd4 || retired !== 32'd1) begin errors++; $display("FAIL x0_pc: got %h/%0d want 4/1", imem_addr, retired); end
  endtask

  task automatic test_illegal;
    int bad;
    apply_reset();
    serve(32'hFFFFFFFF);
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL illegal_decode_halted: got %b want 0", halted); end
    step();
    checks++; if (halted !== 1'b1 || error !== 1'b1) begin errors++; $display("FAIL illegal_halt: got h=%b e=%b want 1/1", halted, error); end
    bad = 0;
    imem_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (write !== 1'b0 || imem_req !== 1'b0) bad++;
    end
    imem_ack = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL illegal_strobes: got %0d bad cycles want 0", bad); end
    checks++; if (imem_addr !== 32'd0 || retired !== 32'd0 || halted !== 1'b1) begin errors++; $display("FAIL illegal_hold: got %h/%0d/%b want 0/0/1", imem_addr, retired, halted); end
  endtask

  task automatic test_system;
    apply_reset();
    serve(32'h00000073);
    step();
    checks++; if (halted !== 1'b1 || error !== 1'b0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL system_halt: got h=%b e=%b req=%b want 1/0/0", halted, error, imem_req);
    end
  endtask

  task automatic test_ack_on_16th;
    apply_reset();
    repeat (15) step();
    serve(32'h00500093);
    step();
    checks++; if (halted !== 1'b0 || write !== 1'b0) begin errors++; $display("FAIL ack16_no_halt: got h=%b w=%b want 0/0", halted, write); end
    step();
    checks++; if (write !== 1'b1) begin errors++; $display("FAIL ack16_wb: got %b want 1", write); end
  endtask

  task automatic test_stall;
    apply_reset();
    repeat (15) step();
    checks++; if (halted !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL stall15: got h=%b req=%b want 0/1", halted, imem_req); end
    step();
`ifdef DECODE_CTRL_FETCH_TIMEOUT_EN
    checks++; if (halted !== 1'b1 || error !== 1'b1 || imem_req !== 1'b0) begin
      errors++; $display("FAIL stall_timeout: got h=%b e=%b req=%b want 1/1/0", halted, error, imem_req);
    end
`else
    repeat (4) step();
    checks++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'd0) begin
      errors++; $display("FAIL stall_wait: got h=%b req=%b addr=%h want 0/1/0", halted, imem_req, imem_addr);
    end
`endif
  endtask

  task automatic test_reset_mid_wb;
    apply_reset();
    serve(32'h00500093);
    step(); step();
    checks++; if (write !== 1'b1) begin errors++; $display("FAIL midwb_pre: got %b want 1", write); end
    #1 reset = 1'b1;
    #1;
    checks++; if (write !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL midwb_async: got w=%b req=%b want 0/0", write, imem_req); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (imem_addr !== 32'd0 || retired !== 32'd0 || imem_req !== 1'b1) begin
      errors++; $display("FAIL midwb_restart: got %h/%0d/%b want 0/0/1", imem_addr, retired, imem_req);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_add_sub();
    test_wait_lui();
    test_x0_dest();
    test_illegal();
    test_system();
    test_ack_on_16th();
    test_stall();
    test_reset_mid_wb();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
